// File: rtl/pipe_controller_pkg.sv
// rtl/pipe_controller_pkg.sv - opcode/funct/ALU codes and pipelined control-word types
package pipe_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam int ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic                  regwrite;
    logic                  regdst;
    logic                  alusrc;
    logic                  memtoreg;
    logic                  memwrite;
    logic                  branch;
    logic                  branch_ne;
    logic [ALU_CODE_W-1:0] alucontrol;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // Later stages only carry the fields they still consume.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } em_word_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } mw_word_t;

endpackage

// File: rtl/pipe_controller_ctrl_decode.sv
// rtl/pipe_controller_ctrl_decode.sv - combinational op/funct decode into a control word
module ctrl_decode
  import pipe_controller_pkg::*;
#(
  parameter bit EXT_OPS = 1'b1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_word_t ctrl,
  output logic       jump,
  output logic       ext_zero,
  output logic       illegal
);

  always_comb begin
    ctrl     = CTRL_BUBBLE;
    jump     = 1'b0;
    ext_zero = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (funct)
          FN_ADD: ctrl.alucontrol = ALU_ADD;
          FN_SUB: ctrl.alucontrol = ALU_SUB;
          FN_AND: ctrl.alucontrol = ALU_AND;
          FN_OR:  ctrl.alucontrol = ALU_OR;
          FN_SLT: ctrl.alucontrol = ALU_SLT;
          FN_XOR: if (EXT_OPS) ctrl.alucontrol = ALU_XOR; else illegal = 1'b1;
          FN_NOR: if (EXT_OPS) ctrl.alucontrol = ALU_NOR; else illegal = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch     = 1'b1;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.branch_ne  = EXT_OPS;
        ctrl.alucontrol = ALU_SUB;
        illegal         = !EXT_OPS;
      end
      OP_ADDI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_AND;
        ext_zero        = 1'b1;
        illegal         = !EXT_OPS;
      end
      OP_ORI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_OR;
        ext_zero        = 1'b1;
        illegal         = !EXT_OPS;
      end
      OP_SLTI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_SLT;
        illegal         = !EXT_OPS;
      end
      OP_J:    jump    = 1'b1;
      default: illegal = 1'b1;
    endcase
    // Anything illegal must reach the pipeline as a harmless bubble.
    if (illegal) begin
      ctrl     = CTRL_BUBBLE;
      jump     = 1'b0;
      ext_zero = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - pipelined MIPS controller with D/E, E/M and M/W control registers
module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter bit EXT_OPS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op_d,
  input  logic [5:0]           funct_d,
  input  logic                 zero_e,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 flush_m,
  output logic                 jump_d,
  output logic                 branch_d,
  output logic                 illegal_d,
  output logic                 ext_zero_d,
  output logic                 regdst_e,
  output logic                 alusrc_e,
  output logic                 memtoreg_e,
  output logic                 regwrite_e,
  output logic [ALUCTRL_W-1:0] alucontrol_e,
  output logic                 pcsrc_e,
  output logic                 memwrite_m,
  output logic                 memtoreg_m,
  output logic                 regwrite_m,
  output logic                 memtoreg_w,
  output logic                 regwrite_w
);

  ctrl_word_t ctrl_d;
  ctrl_word_t de_q;
  em_word_t   em_q;
  mw_word_t   mw_q;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .op       (op_d),
    .funct    (funct_d),
    .ctrl     (ctrl_d),
    .jump     (jump_d),
    .ext_zero (ext_zero_d),
    .illegal  (illegal_d)
  );

  assign branch_d = ctrl_d.branch | ctrl_d.branch_ne;

  // Flush outranks stall so a squashed instruction never lingers in E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        de_q <= CTRL_BUBBLE;
    else if (flush_e)  de_q <= CTRL_BUBBLE;
    else if (!stall_e) de_q <= ctrl_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q <= '0;
    end else if (flush_m) begin
      em_q <= '0;
    end else begin
      em_q.regwrite <= de_q.regwrite;
      em_q.memtoreg <= de_q.memtoreg;
      em_q.memwrite <= de_q.memwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw_q <= '0;
    end else begin
      mw_q.regwrite <= em_q.regwrite;
      mw_q.memtoreg <= em_q.memtoreg;
    end
  end

  assign regdst_e     = de_q.regdst;
  assign alusrc_e     = de_q.alusrc;
  assign memtoreg_e   = de_q.memtoreg;
  assign regwrite_e   = de_q.regwrite;
  assign alucontrol_e = ALUCTRL_W'(de_q.alucontrol);
  assign pcsrc_e      = (de_q.branch & zero_e) | (de_q.branch_ne & ~zero_e);

  assign memwrite_m = em_q.memwrite;
  assign memtoreg_m = em_q.memtoreg;
  assign regwrite_m = em_q.regwrite;
  assign memtoreg_w = mw_q.memtoreg;
  assign regwrite_w = mw_q.regwrite;

endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - self-checking bench for pipe_controller (full and reduced decode)
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_d = '0;
  logic [5:0] funct_d = '0;
  logic       zero_e = 1'b0;
  logic       stall_e = 1'b0;
  logic       flush_e = 1'b0;
  logic       flush_m = 1'b0;

  logic       jump_d, branch_d, illegal_d, ext_zero_d;
  logic       regdst_e, alusrc_e, memtoreg_e, regwrite_e, pcsrc_e;
  logic [3:0] alucontrol_e;
  logic       memwrite_m, memtoreg_m, regwrite_m, memtoreg_w, regwrite_w;

  logic       n_jump_d, n_branch_d, n_illegal_d, n_ext_zero_d;
  logic       n_regdst_e, n_alusrc_e, n_memtoreg_e, n_regwrite_e, n_pcsrc_e;
  logic [7:0] n_alucontrol_e;
  logic       n_memwrite_m, n_memtoreg_m, n_regwrite_m, n_memtoreg_w, n_regwrite_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_controller #(.ALUCTRL_W(4), .EXT_OPS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .funct_d(funct_d), .zero_e(zero_e),
    .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
    .jump_d(jump_d), .branch_d(branch_d), .illegal_d(illegal_d), .ext_zero_d(ext_zero_d),
    .regdst_e(regdst_e), .alusrc_e(alusrc_e), .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e),
    .alucontrol_e(alucontrol_e), .pcsrc_e(pcsrc_e),
    .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m), .regwrite_m(regwrite_m),
    .memtoreg_w(memtoreg_w), .regwrite_w(regwrite_w)
  );

  pipe_controller #(.ALUCTRL_W(8), .EXT_OPS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .funct_d(funct_d), .zero_e(zero_e),
    .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
    .jump_d(n_jump_d), .branch_d(n_branch_d), .illegal_d(n_illegal_d), .ext_zero_d(n_ext_zero_d),
    .regdst_e(n_regdst_e), .alusrc_e(n_alusrc_e), .memtoreg_e(n_memtoreg_e), .regwrite_e(n_regwrite_e),
    .alucontrol_e(n_alucontrol_e), .pcsrc_e(n_pcsrc_e),
    .memwrite_m(n_memwrite_m), .memtoreg_m(n_memtoreg_m), .regwrite_m(n_regwrite_m),
    .memtoreg_w(n_memtoreg_w), .regwrite_w(n_regwrite_w)
  );

  typedef struct packed {
    bit       rw, rd, as, m2r, mw, br, bne;
    bit [3:0] alu;
    bit       ill, jmp, ez;
  } d_t;

  // Instruction table: what each opcode/funct must do, as a flat lookup.
  function automatic d_t dec(bit [5:0] op, bit [5:0] fn, bit ext);
    d_t d;
    d = '0;
    case (op)
      6'h00: begin
        d.rw = 1; d.rd = 1;
        case (fn)
          6'h20: d.alu = 4'd2;
          6'h22: d.alu = 4'd6;
          6'h24: d.alu = 4'd0;
          6'h25: d.alu = 4'd1;
          6'h2a: d.alu = 4'd7;
          6'h26: if (ext) d.alu = 4'd3;  else d.ill = 1;
          6'h27: if (ext) d.alu = 4'd12; else d.ill = 1;
          default: d.ill = 1;
        endcase
      end
      6'h23: begin d.rw = 1; d.as = 1; d.m2r = 1; d.alu = 4'd2; end
      6'h2b: begin d.mw = 1; d.as = 1; d.alu = 4'd2; end
      6'h04: begin d.br = 1; d.alu = 4'd6; end
      6'h05: if (ext) begin d.bne = 1; d.alu = 4'd6; end else d.ill = 1;
      6'h08: begin d.rw = 1; d.as = 1; d.alu = 4'd2; end
      6'h0c: if (ext) begin d.rw = 1; d.as = 1; d.ez = 1; d.alu = 4'd0; end else d.ill = 1;
      6'h0d: if (ext) begin d.rw = 1; d.as = 1; d.ez = 1; d.alu = 4'd1; end else d.ill = 1;
      6'h0a: if (ext) begin d.rw = 1; d.as = 1; d.alu = 4'd7; end else d.ill = 1;
      6'h02: d.jmp = 1;
      default: d.ill = 1;
    endcase
    if (d.ill) begin
      d = '0;
      d.ill = 1;
    end
    return d;
  endfunction

  // Stage contents per instance: index 0 = full decode, 1 = reduced decode.
  d_t me[2];
  d_t mm[2];
  d_t mwb[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        me[i] = '0; mm[i] = '0; mwb[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mwb[i] = mm[i];
        mm[i]  = flush_m ? d_t'(0) : me[i];
        if (flush_e)       me[i] = '0;
        else if (!stall_e) me[i] = dec(op_d, funct_d, (i == 0));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    d_t d0, d1;
    d0 = dec(op_d, funct_d, 1'b1);
    d1 = dec(op_d, funct_d, 1'b0);
    chk("jump_d", 32'(jump_d), 32'(d0.jmp));
    chk("branch_d", 32'(branch_d), 32'(d0.br | d0.bne));
    chk("illegal_d", 32'(illegal_d), 32'(d0.ill));
    chk("ext_zero_d", 32'(ext_zero_d), 32'(d0.ez));
    chk("regdst_e", 32'(regdst_e), 32'(me[0].rd));
    chk("alusrc_e", 32'(alusrc_e), 32'(me[0].as));
    chk("memtoreg_e", 32'(memtoreg_e), 32'(me[0].m2r));
    chk("regwrite_e", 32'(regwrite_e), 32'(me[0].rw));
    chk("alucontrol_e", 32'(alucontrol_e), 32'(me[0].alu));
    chk("pcsrc_e", 32'(pcsrc_e), 32'((me[0].br & zero_e) | (me[0].bne & ~zero_e)));
    chk("memwrite_m", 32'(memwrite_m), 32'(mm[0].mw));
    chk("memtoreg_m", 32'(memtoreg_m), 32'(mm[0].m2r));
    chk("regwrite_m", 32'(regwrite_m), 32'(mm[0].rw));
    chk("memtoreg_w", 32'(memtoreg_w), 32'(mwb[0].m2r));
    chk("regwrite_w", 32'(regwrite_w), 32'(mwb[0].rw));
    chk("n_jump_d", 32'(n_jump_d), 32'(d1.jmp));
    chk("n_branch_d", 32'(n_branch_d), 32'(d1.br | d1.bne));
    chk("n_illegal_d", 32'(n_illegal_d), 32'(d1.ill));
    chk("n_ext_zero_d", 32'(n_ext_zero_d), 32'(d1.ez));
    chk("n_regdst_e", 32'(n_regdst_e), 32'(me[1].rd));
    chk("n_alusrc_e", 32'(n_alusrc_e), 32'(me[1].as));
    chk("n_memtoreg_e", 32'(n_memtoreg_e), 32'(me[1].m2r));
    chk("n_regwrite_e", 32'(n_regwrite_e), 32'(me[1].rw));
    chk("n_alucontrol_e", 32'(n_alucontrol_e), 32'(me[1].alu));
    chk("n_pcsrc_e", 32'(n_pcsrc_e), 32'((me[1].br & zero_e) | (me[1].bne & ~zero_e)));
    chk("n_memwrite_m", 32'(n_memwrite_m), 32'(mm[1].mw));
    chk("n_memtoreg_m", 32'(n_memtoreg_m), 32'(mm[1].m2r));
    chk("n_regwrite_m", 32'(n_regwrite_m), 32'(mm[1].rw));
    chk("n_memtoreg_w", 32'(n_memtoreg_w), 32'(mwb[1].m2r));
    chk("n_regwrite_w", 32'(n_regwrite_w), 32'(mwb[1].rw));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] regs_all();
    return 32'({regdst_e, alusrc_e, memtoreg_e, regwrite_e, alucontrol_e, pcsrc_e,
                memwrite_m, memtoreg_m, regwrite_m, memtoreg_w, regwrite_w,
                n_regdst_e, n_alusrc_e, n_memtoreg_e, n_regwrite_e, n_alucontrol_e[3:0],
                n_pcsrc_e, n_memwrite_m, n_memtoreg_m, n_regwrite_m, n_memtoreg_w, n_regwrite_w});
  endfunction

  int cnt;

  initial begin
    #2;
    chk("reset_regs", regs_all(), 32'd0);
    chk("reset_n_alu_hi", 32'(n_alucontrol_e), 32'd0);
    chk("reset_illegal_d", 32'(illegal_d), 32'd1);
    step();
    rst_n = 1'b1;

    op_d = 6'h23;
    step();
    chk("lw_alusrc_e", 32'(alusrc_e), 32'd1);
    chk("lw_alucontrol_e", 32'(alucontrol_e), 32'h2);
    chk("lw_n_alucontrol_e", 32'(n_alucontrol_e), 32'h02);
    op_d = 6'h00; funct_d = 6'h20;
    step();
    chk("lw_memtoreg_m", 32'(memtoreg_m), 32'd1);
    op_d = 6'h02;
    #1;
    chk("j_jump_d", 32'(jump_d), 32'd1);
    step();
    chk("lw_regwrite_w", 32'(regwrite_w), 32'd1);
    chk("lw_memtoreg_w", 32'(memtoreg_w), 32'd1);

    op_d = 6'h04; zero_e = 1'b1;
    step();
    chk("beq_taken", 32'(pcsrc_e), 32'd1);
    op_d = 6'h05;
    step();
    chk("bne_zero1", 32'(pcsrc_e), 32'd0);
    zero_e = 1'b0;
    #1;
    chk("bne_zero0", 32'(pcsrc_e), 32'd1);
    chk("bne_reduced", 32'(n_pcsrc_e), 32'd0);

    op_d = 6'h00; funct_d = 6'h27;
    #1;
    chk("nor_legal", 32'(illegal_d), 32'd0);
    chk("nor_illegal_reduced", 32'(n_illegal_d), 32'd1);
    step();
    chk("nor_alucontrol_e", 32'(alucontrol_e), 32'hc);
    chk("nor_regwrite_e", 32'(regwrite_e), 32'd1);
    chk("nor_n_regwrite_e", 32'(n_regwrite_e), 32'd0);

    op_d = 6'h2b;
    step();
    stall_e = 1'b1; flush_m = 1'b1; op_d = 6'h08;
    cnt = 0;
    repeat (2) begin step(); cnt += int'(memwrite_m); end
    stall_e = 1'b0; flush_m = 1'b0;
    repeat (2) begin step(); cnt += int'(memwrite_m); end
    chk("sw_stall_once", 32'(cnt), 32'd1);

    op_d = 6'h23; stall_e = 1'b1; flush_e = 1'b1;
    step();
    chk("flush_wins", 32'({regdst_e, alusrc_e, memtoreg_e, regwrite_e, alucontrol_e, pcsrc_e}), 32'd0);
    stall_e = 1'b0; flush_e = 1'b0;

    op_d = 6'h08;
    step();
    op_d = 6'h0c;
    #1;
    chk("andi_ext_zero", 32'(ext_zero_d), 32'd1);
    chk("andi_n_ext_zero", 32'(n_ext_zero_d), 32'd0);
    step();
    op_d = 6'h0d;
    step();
    op_d = 6'h0a;
    step();
    chk("slti_alucontrol_e", 32'(alucontrol_e), 32'h7);
    chk("stream_regwrite_m", 32'(regwrite_m), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_regs", regs_all(), 32'd0);
    step();
    step();
    chk("midrst_hold", regs_all(), 32'd0);
    rst_n = 1'b1;
    op_d = 6'h00; funct_d = 6'h20;
    step();
    chk("post_rst_alu", 32'(alucontrol_e), 32'h2);
    chk("post_rst_w", 32'(regwrite_w), 32'd0);
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
